// File: rtl/wm_pkg.sv
// rtl/wm_pkg.sv - shared state encodings and defaults for the washing-machine controller
// Contents:
//   STATE_W              width of the state bus shared with the timer stage
//   state_t              FSM state encodings (same values as the timer's STATE_*)
//   DEFAULT_RINSE_CYCLES default number of rinse passes
//   DEFAULT_TIMEOUT      default watchdog limit in cycles
//   is_timed()           true for states supervised by the watchdog (2..6)
package wm_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    STATE_IDLE        = 3'd0,
    STATE_CHECK_DOOR  = 3'd1,
    STATE_FILL_WATER  = 3'd2,
    STATE_HEAT_WATER  = 3'd3,
    STATE_WASH        = 3'd4,
    STATE_RINSE       = 3'd5,
    STATE_SPIN        = 3'd6,
    STATE_FAULT       = 3'd7
  } state_t;

  localparam int         DEFAULT_RINSE_CYCLES = 2;
  localparam logic [7:0] DEFAULT_TIMEOUT      = 8'd200;

  function automatic logic is_timed(input state_t s);
    return (s >= STATE_FILL_WATER) && (s <= STATE_SPIN);
  endfunction

endpackage

// File: rtl/wm_watchdog.sv
// rtl/wm_watchdog.sv - saturating 8-bit no-progress watchdog
// Ports:
//   clock    in  system clock, rising edge
//   reset_n  in  asynchronous active-low reset
//   clear    in  restart the count (state change or rinse pass)
//   enable   in  count this cycle (timed states only)
//   expired  out count has reached TIMEOUT
module wm_watchdog
  import wm_pkg::*;
#(
  parameter logic [7:0] TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable && (count != TIMEOUT)) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == TIMEOUT);

endmodule

// File: rtl/wm_controller.sv
// rtl/wm_controller.sv - main sequencing FSM of the washing-machine controller
// Ports:
//   clock, reset_n                         clock and asynchronous active-low reset
//   start, cancel, door_closed             user controls and door sensor
//   sig_Full, sig_Temperature, sig_Completed  phase-complete flags from the timer
//   state                                  current FSM state, fed to the timer
//   door_lock, water_valve, heater_on,
//   motor_on, drain_valve                  actuator enables (Moore decode)
//   done                                   one-cycle pulse when a program ends
//   fault                                  high while in FAULT
module wm_controller
  import wm_pkg::*;
#(
  parameter int         RINSE_CYCLES = DEFAULT_RINSE_CYCLES,
  parameter logic [7:0] TIMEOUT      = DEFAULT_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic                cancel,
  input  logic                door_closed,
  input  logic                sig_Full,
  input  logic                sig_Temperature,
  input  logic                sig_Completed,
  output logic [STATE_W-1:0]  state,
  output logic                door_lock,
  output logic                water_valve,
  output logic                heater_on,
  output logic                motor_on,
  output logic                drain_valve,
  output logic                done,
  output logic                fault
);

  localparam logic [1:0] RINSE_LAST = 2'(RINSE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [1:0] rinse_cnt, rinse_d;
  logic       rinse_pass;
  logic       wd_expired;
  logic       done_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= STATE_IDLE;
      rinse_cnt <= 2'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rinse_cnt <= rinse_d;
      // Registered so the pulse lines up with state returning to IDLE.
      done_q    <= (state_q == STATE_SPIN) && (state_d == STATE_IDLE);
    end
  end

  always_comb begin
    state_d    = state_q;
    rinse_d    = rinse_cnt;
    rinse_pass = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (start && door_closed) state_d = STATE_CHECK_DOOR;
      end
      STATE_CHECK_DOOR: begin
        state_d = (door_closed && !cancel) ? STATE_FILL_WATER : STATE_IDLE;
      end
      STATE_FAULT: begin
        if (cancel) state_d = STATE_IDLE;
      end
      default: begin
        // Timed states: fault beats cancel beats the state's own progress flag.
        if (!door_closed || wd_expired) begin
          state_d = STATE_FAULT;
        end else if (cancel && (state_q != STATE_SPIN)) begin
          // Cancel always goes through SPIN so the drum is drained.
          state_d = STATE_SPIN;
        end else begin
          case (state_q)
            STATE_FILL_WATER: if (sig_Full)        state_d = STATE_HEAT_WATER;
            STATE_HEAT_WATER: if (sig_Temperature) state_d = STATE_WASH;
            STATE_WASH: begin
              if (sig_Completed) begin
                state_d = STATE_RINSE;
                rinse_d = 2'd0;
              end
            end
            STATE_RINSE: begin
              if (sig_Completed) begin
                if (rinse_cnt == RINSE_LAST) begin
                  state_d = STATE_SPIN;
                end else begin
                  rinse_d    = rinse_cnt + 2'd1;
                  rinse_pass = 1'b1;
                end
              end
            end
            STATE_SPIN: if (sig_Completed) state_d = STATE_IDLE;
            default: ;
          endcase
        end
      end
    endcase
  end

  wm_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   ((state_d != state_q) || rinse_pass),
    .enable  (is_timed(state_q)),
    .expired (wd_expired)
  );

  always_comb begin
    door_lock   = 1'b0;
    water_valve = 1'b0;
    heater_on   = 1'b0;
    motor_on    = 1'b0;
    drain_valve = 1'b0;
    fault       = 1'b0;
    case (state_q)
      STATE_CHECK_DOOR: door_lock = 1'b1;
      STATE_FILL_WATER: begin door_lock = 1'b1; water_valve = 1'b1; end
      STATE_HEAT_WATER: begin door_lock = 1'b1; heater_on = 1'b1; end
      STATE_WASH:       begin door_lock = 1'b1; motor_on = 1'b1; end
      STATE_RINSE:      begin door_lock = 1'b1; water_valve = 1'b1; motor_on = 1'b1; end
      STATE_SPIN:       begin door_lock = 1'b1; motor_on = 1'b1; drain_valve = 1'b1; end
      STATE_FAULT:      fault = 1'b1;
      default: ;
    endcase
  end

  assign state = state_q;
  assign done  = done_q;

endmodule

// File: tb/tb_wm_controller.sv
// tb/tb_wm_controller.sv - self-checking bench for wm_controller against a behavioural model
module tb_wm_controller;

  localparam int RINSE_N = 2;
  localparam int TMO     = 20;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, cancel = 1'b0, door_closed = 1'b1;
  logic       sig_Full = 1'b0, sig_Temperature = 1'b0, sig_Completed = 1'b0;
  logic [2:0] state;
  logic       door_lock, water_valve, heater_on, motor_on, drain_valve, done, fault;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural reference: program position, rinse passes done, cycles spent
  // without progress in the current step, and the done pulse.
  int m_state, m_rinse, m_age, m_done;

  wm_controller #(
    .RINSE_CYCLES (RINSE_N),
    .TIMEOUT      (8'(TMO))
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .start           (start),
    .cancel          (cancel),
    .door_closed     (door_closed),
    .sig_Full        (sig_Full),
    .sig_Temperature (sig_Temperature),
    .sig_Completed   (sig_Completed),
    .state           (state),
    .door_lock       (door_lock),
    .water_valve     (water_valve),
    .heater_on       (heater_on),
    .motor_on        (motor_on),
    .drain_valve     (drain_valve),
    .done            (done),
    .fault           (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // {door_lock, water_valve, heater_on, motor_on, drain_valve, fault}
  function automatic int exp_act(input int s);
    case (s)
      1: return 'b100000;
      2: return 'b110000;
      3: return 'b101000;
      4: return 'b100100;
      5: return 'b110100;
      6: return 'b100110;
      7: return 'b000001;
      default: return 0;
    endcase
  endfunction

  function automatic int act_vec();
    return {26'd0, door_lock, water_valve, heater_on, motor_on, drain_valve, fault};
  endfunction

  task automatic model_reset();
    m_state = 0; m_rinse = 0; m_age = 0; m_done = 0;
  endtask

  task automatic model_step();
    int nxt;
    bit progressed;
    nxt = m_state;
    progressed = 0;
    if (m_state == 0) begin
      if (start && door_closed) nxt = 1;
    end else if (m_state == 1) begin
      nxt = (door_closed && !cancel) ? 2 : 0;
    end else if (m_state == 7) begin
      if (cancel) nxt = 0;
    end else if (!door_closed || m_age >= TMO) begin
      nxt = 7;
    end else if (cancel && m_state != 6) begin
      nxt = 6;
    end else if (m_state == 2 && sig_Full) begin
      nxt = 3;
    end else if (m_state == 3 && sig_Temperature) begin
      nxt = 4;
    end else if (sig_Completed) begin
      if (m_state == 4) begin
        nxt = 5; m_rinse = 0;
      end else if (m_state == 5) begin
        if (m_rinse + 1 >= RINSE_N) nxt = 6;
        else begin m_rinse++; progressed = 1; end
      end else if (m_state == 6) begin
        nxt = 0;
      end
    end
    m_done = (m_state == 6 && nxt == 0);
    if (nxt != m_state || progressed) m_age = 0;
    else if (m_state >= 2 && m_state <= 6 && m_age < TMO) m_age++;
    m_state = nxt;
  endtask

  task automatic compare_all();
    check("state", state, m_state);
    check("actuators", act_vec(), exp_act(m_state));
    check("done", done, m_done);
  endtask

  // One clock: DUT and model both sample the current inputs, then compare.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    start = 0; cancel = 0; sig_Full = 0; sig_Temperature = 0; sig_Completed = 0;
  endtask

  task automatic pulse_start();
    start = 1; cyc(); start = 0;
  endtask

  task automatic go_to(input int target);
    pulse_start();        // -> CHECK_DOOR
    cyc();                // -> FILL_WATER
    if (target >= 3) begin sig_Full = 1; cyc(); sig_Full = 0; end
    if (target >= 4) begin sig_Temperature = 1; cyc(); sig_Temperature = 0; end
    if (target >= 5) begin sig_Completed = 1; cyc(); sig_Completed = 0; end
  endtask

  task automatic async_reset_pulse();
    #2 reset_n = 0;
    model_reset();
    #1;
    compare_all();
    check("reset_outputs_zero", act_vec() | int'(done), 0);
    @(negedge clock);
    reset_n = 1;
  endtask

  initial begin
    int seq[$];
    int exp_seq[$];
    model_reset();
    #1;
    compare_all();
    check("reset_fault", fault, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1;

    // Normal program: 0,1,2,3,4,5,5,6,0 with done only on the final step.
    door_closed = 1;
    exp_seq = '{1, 2, 3, 4, 5, 5, 6, 0};
    pulse_start();                         seq.push_back(int'(state));
    cyc();                                 seq.push_back(int'(state));
    sig_Full = 1; cyc(); sig_Full = 0;     seq.push_back(int'(state));
    sig_Temperature = 1; cyc(); sig_Temperature = 0; seq.push_back(int'(state));
    for (int i = 0; i < 4; i++) begin
      check("done_early", done, 0);
      sig_Completed = 1; cyc(); sig_Completed = 0;
      seq.push_back(int'(state));
    end
    for (int i = 0; i < 8; i++) check($sformatf("normal_seq%0d", i), seq[i], exp_seq[i]);
    check("normal_done_pulse", done, 1);
    cyc();
    check("normal_done_one_cycle", done, 0);

    // Door open at start: ignored for 10 cycles.
    door_closed = 0; start = 1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("door_open_state", state, 0);
      check("door_open_lock", door_lock, 0);
    end
    clear_inputs(); door_closed = 1;

    // Cancel in WASH drains through SPIN.
    go_to(4);
    cancel = 1; cyc(); cancel = 0;
    check("cancel_wash_state", state, 6);
    check("cancel_wash_drain", drain_valve, 1);
    sig_Completed = 1; cyc(); sig_Completed = 0;
    check("cancel_wash_idle", state, 0);
    check("cancel_wash_done", done, 1);
    cyc();

    // Door opened while heating.
    go_to(3);
    door_closed = 0; cyc();
    check("door_fault_state", state, 7);
    check("door_fault_flag", fault, 1);
    door_closed = 1; cyc();
    check("fault_holds", state, 7);
    cancel = 1; cyc(); cancel = 0;
    check("fault_clear", state, 0);

    // Watchdog: FAULT visible TIMEOUT+1 cycles after entering FILL_WATER.
    pulse_start(); cyc();
    check("wd_entry", state, 2);
    for (int i = 1; i <= TMO + 1; i++) begin
      cyc();
      if (i == TMO) check("wd_not_yet", state, 2);
    end
    check("wd_fault", state, 7);
    cancel = 1; cyc(); cancel = 0;

    // Progress on cycle TIMEOUT-1 escapes the fault.
    pulse_start(); cyc();
    for (int i = 1; i <= TMO - 1; i++) cyc();
    sig_Full = 1; cyc(); sig_Full = 0;
    check("wd_escape_state", state, 3);
    check("wd_escape_fault", fault, 0);
    cancel = 1; cyc(); cancel = 0;
    sig_Completed = 1; cyc(); sig_Completed = 0;
    cyc();

    // Async reset mid-RINSE, then a clean restart with both rinse passes.
    go_to(5);
    check("pre_reset_rinse", state, 5);
    async_reset_pulse();
    go_to(5);
    sig_Completed = 1; cyc();
    check("restart_rinse2", state, 5);
    cyc();
    check("restart_spin", state, 6);
    cyc(); sig_Completed = 0;
    check("restart_done", done, 1);
    cyc();

    // Randomised traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      door_closed     = ($urandom_range(0, 99) < 97);
      start           = ($urandom_range(0, 99) < 30);
      cancel          = ($urandom_range(0, 99) < 4);
      sig_Full        = ($urandom_range(0, 99) < 15);
      sig_Temperature = ($urandom_range(0, 99) < 15);
      sig_Completed   = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 499) == 0) async_reset_pulse();
      else cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wm_controller.md
# wm_controller

Main sequencing FSM of the washing-machine controller. Accepts user controls (start, cancel, door sensor) and the phase-complete flags from the timer stage (`sig_Full`, `sig_Temperature`, `sig_Completed`). Drives the 3-bit `state` bus that the timer consumes, plus the actuator enables. It sits directly upstream of the timer, and the two form a closed loop: controller state → timer → completion flags → controller.

## Interface
Parameters:
- `RINSE_CYCLES`, default 2: number of rinse passes; legal range 1..3.
- `TIMEOUT`, default 8'd200: maximum cycles allowed in any timed state (2..6) before a fault.

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: level; begins a program from IDLE.
- `cancel` in 1: level; aborts the program or clears a fault.
- `door_closed` in 1: door sensor; 1 = closed.
- `sig_Full` in 1: timer flag; drum full.
- `sig_Temperature` in 1: timer flag; water at temperature.
- `sig_Completed` in 1: timer flag; current timed phase finished.
- `state` out 3: current FSM state, fed to the timer.
- `door_lock` out 1: door lock solenoid.
- `water_valve` out 1: inlet valve.
- `heater_on` out 1: heater.
- `motor_on` out 1: drum motor.
- `drain_valve` out 1: drain pump/valve.
- `done` out 1: one-cycle pulse at program end.
- `fault` out 1: high while in FAULT.

## Operation
State encodings:
- IDLE = 0
- CHECK_DOOR = 1
- FILL_WATER = 2
- HEAT_WATER = 3
- WASH = 4
- RINSE = 5
- SPIN = 6
- FAULT = 7

Transitions:
- IDLE → CHECK_DOOR when `start & door_closed`. `start` with the door open is ignored.
- CHECK_DOOR: `door_closed & !cancel` → FILL_WATER; otherwise → IDLE.
- FILL_WATER → HEAT_WATER on `sig_Full`.
- HEAT_WATER → WASH on `sig_Temperature`.
- WASH → RINSE on `sig_Completed`; `rinse_cnt` is cleared to 0.
- RINSE on `sig_Completed`:
  - if `rinse_cnt == RINSE_CYCLES-1` → SPIN;
  - else `rinse_cnt` increments, the state stays RINSE, and the watchdog restarts.
- SPIN → IDLE on `sig_Completed`; `done` = 1 for exactly that one cycle.
- Cancel in states 2..5 → SPIN, so water is always drained. Cancel in SPIN is ignored.
- FAULT → IDLE on `cancel`. Everything else is ignored.

Fault conditions (states 2..6 only):
- `door_closed == 0`;
- watchdog count reaching `TIMEOUT` with no progress event.

Priority per cycle: fault > cancel > progress flag. Flags that do not belong to the current state are ignored. Example: `sig_Completed` in FILL_WATER has no effect.

Watchdog:
- 8-bit counter, cleared on every state change and on every rinse pass.
- Counts while in states 2..6 and saturates at `TIMEOUT`.

Actuator decode (Moore, taken from the state register only):
- FILL_WATER: `water_valve`.
- HEAT_WATER: `heater_on`.
- WASH: `motor_on`.
- RINSE: `water_valve`, `motor_on`.
- SPIN: `motor_on`, `drain_valve`.
- `door_lock` = 1 in states 1..6.
- FAULT: all actuators 0, `door_lock` = 0, `fault` = 1.

## Timing
- Reset (async assert, sync release):
  - `state` = IDLE, `rinse_cnt` = 0, watchdog = 0;
  - all outputs 0, including `done` and `fault`.
- Reset mid-program returns to IDLE immediately, with actuators off within the same cycle as assertion.
- All inputs are sampled on the rising edge of `clock`. The next state is visible on `state` the cycle after the qualifying input.
- Actuator outputs change in the same cycle as `state`. There is no extra register stage.
- `done` is registered and high for exactly 1 cycle, aligned with `state` becoming IDLE.
- Timer flags are treated as levels; each state acts on the first sampled high.
- A fault fires on the edge where the watchdog equals `TIMEOUT`: FAULT becomes visible `TIMEOUT+1` cycles after state entry.
- Simultaneous `start` and `cancel` in IDLE: go to CHECK_DOOR. CHECK_DOOR then sees `cancel` and returns to IDLE.

## Structure
- Shared package `wm_pkg` holds:
  - state encodings (matching the timer's existing `STATE_*` values);
  - a 3-bit state typedef/width constant;
  - default `RINSE_CYCLES` and `TIMEOUT`.
  - The timer stage is to be moved onto the same package.
- One sub-module, `wm_watchdog`: clear/enable/saturating 8-bit counter with a `expired` output. The FSM, rinse counter and output decode stay in `wm_controller`.

## Test plan
- Normal program:
  - stimulus: reset, door_closed=1, `start` pulse, then `sig_Full`, `sig_Temperature`, then four `sig_Completed` pulses (wash, rinse×2, spin);
  - required: state sequence 0,1,2,3,4,5,5,6,0; `done` high for exactly 1 cycle; actuators per decode in each state.
- Door open at start:
  - stimulus: `start`=1 with door_closed=0 for 10 cycles;
  - required: `state` stays 0, `door_lock` stays 0.
- Cancel in WASH:
  - required: next state 6 with `drain_valve`=1;
  - then `sig_Completed` → IDLE with `done` pulsed.
- Door opened in HEAT_WATER:
  - required: FAULT (7) next cycle, all actuators 0, `fault`=1;
  - `cancel` → IDLE.
- Watchdog:
  - stimulus: TIMEOUT=8'd20, hold FILL_WATER with no `sig_Full`;
  - required: FAULT visible 21 cycles after entry.
  - `sig_Full` asserted on cycle 19 instead → HEAT_WATER with no fault.
- Async reset asserted mid-RINSE:
  - required: outputs 0 immediately;
  - after release, `start` restarts cleanly with `rinse_cnt` starting at 0.
